// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access sequencer: RV32I width codes,
// FSM state encoding and request legality helpers.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int LANE_W  = 2;
    localparam int SHAMT_W = 5;
    localparam int BYTE_W  = 8;
    localparam int HALF_W  = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RMW_RD = 3'd2,
        S_STORE  = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    function automatic logic f3_legal(input logic write, input logic [2:0] f3);
        if (write)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [LANE_W-1:0] lo);
        if ((f3 == F3_H) || (f3 == F3_HU))
            return lo[0];
        if (f3 == F3_W)
            return lo != 2'b00;
        return 1'b0;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte/halfword lane handling: extracts and extends load data from a memory
// word, and merges narrow store data into a word for read-modify-write.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0]       word,
    input  logic [LANE_W-1:0] addr_lo,
    input  logic [2:0]        funct3,
    input  logic [31:0]       wdata,
    output logic [31:0]       load_val,
    output logic [31:0]       merged
);

    logic [SHAMT_W-1:0] byte_sh;
    logic [SHAMT_W-1:0] half_sh;
    logic [BYTE_W-1:0]  byte_lane;
    logic [HALF_W-1:0]  half_lane;

    always_comb begin
        byte_sh   = {addr_lo, 3'b000};
        half_sh   = {addr_lo[1], 4'b0000};
        byte_lane = BYTE_W'(word >> byte_sh);
        half_lane = HALF_W'(word >> half_sh);

        case (funct3)
            F3_B:    load_val = {{24{byte_lane[7]}}, byte_lane};
            F3_BU:   load_val = {24'h000000, byte_lane};
            F3_H:    load_val = {{16{half_lane[15]}}, half_lane};
            F3_HU:   load_val = {16'h0000, half_lane};
            default: load_val = word;
        endcase

        // Only the addressed lane changes; the rest of the fetched word is kept.
        case (funct3)
            F3_B:    merged = (word & ~(32'h0000_00FF << byte_sh)) |
                              (32'(wdata[BYTE_W-1:0]) << byte_sh);
            F3_H:    merged = (word & ~(32'h0000_FFFF << half_sh)) |
                              (32'(wdata[HALF_W-1:0]) << half_sh);
            default: merged = wdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer between the CPU datapath and a word-addressed memory
// with asynchronous read and synchronous write; narrow stores use RMW.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int MEM_DEPTH = 16384
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_dout
);

    state_t            state;
    logic [2:0]        f3_q;
    logic [LANE_W-1:0] lo_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [31:0]       mem_addr_q;
    logic [31:0]       mem_din_q;
    logic [31:0]       load_val;
    logic [31:0]       merged;
    logic              req_err;

    // mem_din_q holds the raw store data until the RMW read replaces it.
    mem_lane_align u_align (
        .word     (mem_dout),
        .addr_lo  (lo_q),
        .funct3   (f3_q),
        .wdata    (mem_din_q),
        .load_val (load_val),
        .merged   (merged)
    );

    always_comb begin
        req_err = !f3_legal(req_write, req_funct3) ||
                  misaligned(req_funct3, req_addr[1:0]) ||
                  ({2'b00, req_addr[31:2]} >= 32'(MEM_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            err_q      <= 1'b0;
            rdata_q    <= 32'h0;
            mem_addr_q <= 32'h0;
            mem_din_q  <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        f3_q       <= req_funct3;
                        lo_q       <= req_addr[1:0];
                        err_q      <= req_err;
                        rdata_q    <= 32'h0;
                        mem_addr_q <= {req_addr[31:2], 2'b00};
                        mem_din_q  <= req_wdata;
                        if (req_err)
                            state <= S_RESP;
                        else if (!req_write)
                            state <= S_LOAD;
                        else if (req_funct3 == F3_W)
                            state <= S_STORE;
                        else
                            state <= S_RMW_RD;
                    end
                end
                S_LOAD: begin
                    rdata_q <= load_val;
                    state   <= S_RESP;
                end
                S_RMW_RD: begin
                    mem_din_q <= merged;
                    state     <= S_STORE;
                end
                S_STORE: state <= S_RESP;
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Gating with !reset guarantees a reset cycle can never commit a write.
    assign req_ready  = !reset && (state == S_IDLE);
    assign mem_read   = !reset && ((state == S_LOAD) || (state == S_RMW_RD));
    assign mem_write  = !reset && (state == S_STORE);
    assign resp_valid = !reset && (state == S_RESP);
    assign resp_err   = resp_valid && err_q;
    assign resp_rdata = resp_valid ? rdata_q : 32'h0;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;

endmodule
